// File: rtl/fp_norm_seq.sv
// Normalisation sequencer for the FP adder back end: finds the leading one of the
// raw post-add magnitude, shifts it to the hidden-bit position and re-biases the exponent.

module pr_circuit_25x25 (
  input  logic [24:0] req,
  output logic [24:0] gnt
);
  logic found;

  // Highest set bit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 24; i >= 0; i--) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
endmodule

module fp_norm_seq #(
  parameter int EXP_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [24:0]      in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [22:0]      out_frac,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_unf,
  output logic [CNT_W-1:0] done_cnt
);
  localparam logic [EXP_W-1:0]        EXP_MAX   = '1;
  localparam logic signed [EXP_W+1:0] EXP_MAX_S = $signed({2'b00, EXP_MAX});
  localparam logic signed [EXP_W+1:0] ONE_S     = 1;
  localparam logic signed [EXP_W+1:0] ZERO_S    = 0;

  typedef enum logic [1:0] {IDLE, DETECT, SHIFT, DONE} state_t;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [22:0]      frac;
    logic             zero;
    logic             ovf;
    logic             unf;
  } res_t;

  state_t state, state_nxt;

  logic             sign_p0;
  logic [EXP_W-1:0] exp_p0;
  logic [24:0]      mant_p0;
  logic             carry_p1;
  logic             zero_p1;
  logic [4:0]       lsh_p1;
  logic [24:0]      onehot;
  logic [4:0]       lead_idx;
  res_t             res;

  // Exponent saturation to Inf and flush-to-zero live here; the Inf/NaN code passes through untouched.
  function automatic res_t normalise(input logic [EXP_W-1:0] e, input logic [24:0] m,
                                     input logic carry, input logic zero, input logic [4:0] s);
    res_t                    r;
    logic signed [EXP_W+1:0] e_s;
    logic signed [EXP_W+1:0] adj;
    logic [22:0]             m_sh;
    r    = '0;
    e_s  = $signed({2'b00, e});
    m_sh = 23'(m << s);
    if (e == EXP_MAX) begin
      r.exp  = EXP_MAX;
      r.frac = m[22:0];
    end else if (zero) begin
      r.zero = 1'b1;
    end else if (carry) begin
      adj = e_s + ONE_S;
      if (adj >= EXP_MAX_S) begin
        r.exp = EXP_MAX;
        r.ovf = 1'b1;
      end else begin
        r.exp  = adj[EXP_W-1:0];
        r.frac = m[23:1];
      end
    end else begin
      adj = e_s - $signed((EXP_W+2)'(s));
      if (adj <= ZERO_S) begin
        r.unf = 1'b1;
      end else begin
        r.exp  = adj[EXP_W-1:0];
        r.frac = m_sh;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = DETECT;
      end
      DETECT: state_nxt = SHIFT;
      SHIFT:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand capture on the accept edge
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      sign_p0 <= in_sign;
      exp_p0  <= in_exp;
      mant_p0 <= in_mant;
    end
  end

  pr_circuit_25x25 u_pr (
    .req (mant_p0),
    .gnt (onehot)
  );

  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < 25; i++) begin
      if (onehot[i]) lead_idx = 5'(i);
    end
  end

  // Stage p1: leading-one position encoded as carry / zero / left-shift amount
  always_ff @(posedge clk) begin
    if (state == DETECT) begin
      carry_p1 <= onehot[24];
      zero_p1  <= (onehot == '0);
      lsh_p1   <= 5'd23 - lead_idx;
    end
  end

  assign res = normalise(exp_p0, mant_p0, carry_p1, zero_p1, lsh_p1);

  // Stage p2: result registers, held through DONE; flags drop on leaving DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sign <= 1'b0;
      out_exp  <= '0;
      out_frac <= '0;
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
    end else if (state == SHIFT) begin
      out_sign <= sign_p0;
      out_exp  <= res.exp;
      out_frac <= res.frac;
      out_zero <= res.zero;
      out_ovf  <= res.ovf;
      out_unf  <= res.unf;
    end else if (state == DONE && out_ready) begin
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        done_cnt <= '0;
    else if (state == DONE && out_ready) done_cnt <= done_cnt + 1'b1;
  end
endmodule

// File: tb/tb_fp_norm_seq.sv
// Randomised scoreboard bench for fp_norm_seq against a doubling-loop normalisation model.

module tb_fp_norm_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid, out_ready, out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_zero, out_ovf, out_unf;
  logic [15:0] done_cnt;

  fp_norm_seq #(.EXP_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_frac(out_frac), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_unf(out_unf), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  e;
    logic [22:0] f;
    logic        z, o, u;
    int          rec;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hs_cnt = 0;
  logic prev_valid = 1'b0;
  logic rnd_rdy = 1'b0;
  exp_t last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: normalise by doubling the magnitude until the hidden bit is reached.
  function automatic exp_t model(input logic s, input logic [7:0] e, input logic [24:0] m);
    exp_t r;
    int   ee, mm;
    r.sign = s; r.e = 8'h00; r.f = '0; r.z = 0; r.o = 0; r.u = 0; r.rec = 0;
    ee = int'(e);
    mm = int'(m);
    if (ee == 255) begin
      r.e = 8'hFF;
      r.f = m[22:0];
    end else if (mm == 0) begin
      r.z = 1;
    end else if (mm >= (1 << 24)) begin
      if (ee + 1 >= 255) begin
        r.e = 8'hFF;
        r.o = 1;
      end else begin
        r.e = 8'(ee + 1);
        r.f = 23'((mm / 2) % (1 << 23));
      end
    end else begin
      while (mm < (1 << 23)) begin
        mm = mm * 2;
        ee = ee - 1;
      end
      if (ee <= 0) r.u = 1;
      else begin
        r.e = 8'(ee);
        r.f = 23'(mm - (1 << 23));
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic s, input logic [7:0] e, input logic [24:0] m);
    exp_t x;
    for (int k = 0; k < 200 && !in_ready; k++) step();
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    x = model(s, e, m);
    x.rec = cyc;
    last = x;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    exp_q.push_back(x);
    step();
    in_valid = 1'b0;
    in_sign = 1'($urandom); in_exp = 8'($urandom); in_mant = 25'($urandom);
  endtask

  // Monitor: latency on the rising edge of out_valid, full compare on each output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hs_cnt = 0;
      prev_valid = 1'b0;
    end else begin
      if (out_valid && exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        if (!prev_valid) check("latency", 32'(cyc - exp_q[0].rec), 32'd3);
        if (out_ready) begin
          exp_t x;
          x = exp_q.pop_front();
          check("sign", 32'(out_sign), 32'(x.sign));
          check("exp", 32'(out_exp), 32'(x.e));
          check("frac", 32'(out_frac), 32'(x.f));
          check("zero", 32'(out_zero), 32'(x.z));
          check("ovf", 32'(out_ovf), 32'(x.o));
          check("unf", 32'(out_unf), 32'(x.u));
          check("done_cnt", 32'(done_cnt), 32'(16'(hs_cnt)));
          hs_cnt++;
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [24:0] mask;
    int          n;
    logic [7:0]  e;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_exp", 32'(out_exp), 32'd0);
    check("rst_out_frac", 32'(out_frac), 32'd0);
    check("rst_flags", {29'd0, out_zero, out_ovf, out_unf}, 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;

    issue(1'b0, 8'h80, 25'h1000000);
    issue(1'b0, 8'h80, 25'h0000001);
    issue(1'b1, 8'h45, 25'h0000000);
    issue(1'b0, 8'h0A, 25'h0000100);
    issue(1'b1, 8'h00, 25'h0800000);
    issue(1'b0, 8'hFE, 25'h1000000);
    issue(1'b1, 8'hFF, 25'h0400001);
    issue(1'b0, 8'h18, 25'h0000001);
    issue(1'b0, 8'h17, 25'h0000001);
    drain();

    // Back-pressure: results must hold while out_ready stays low.
    out_ready = 1'b0;
    issue(1'b1, 8'hFE, 25'h1FFFFFF);
    for (int k = 0; k < 20 && !out_valid; k++) step();
    check("hold_valid_rise", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0]; in_exp = 8'($urandom); in_mant = 25'($urandom);
      step();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_exp", 32'(out_exp), 32'(last.e));
      check("hold_frac", 32'(out_frac), 32'(last.f));
      check("hold_ovf", 32'(out_ovf), 32'(last.o));
      check("hold_done_cnt", 32'(done_cnt), 32'(16'(hs_cnt)));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_ovf_clear", 32'(out_ovf), 32'd0);
    check("release_done_cnt", 32'(done_cnt), 32'(16'(hs_cnt)));
    check("release_queue", 32'(exp_q.size()), 32'd0);

    rnd_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      n = $urandom_range(0, 25);
      mask = (n == 25) ? 25'h1FFFFFF : ((25'd1 << n) - 25'd1);
      case ($urandom_range(0, 5))
        0:       e = 8'h00;
        1:       e = 8'hFE;
        2:       e = 8'hFF;
        3:       e = 8'($urandom_range(0, 30));
        default: e = 8'($urandom);
      endcase
      issue(1'($urandom), e, 25'($urandom) & mask);
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset while an operation sits in SHIFT.
    issue(1'b1, 8'h90, 25'h0123456);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_sign", 32'(out_sign), 32'd0);
    check("async_out_exp", 32'(out_exp), 32'd0);
    check("async_out_frac", 32'(out_frac), 32'd0);
    check("async_done_cnt", 32'(done_cnt), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step();
    issue(1'b0, 8'h40, 25'h0000F00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
